// File: rtl/handshake_constant_check.sv
// Consumes valid/ready data tokens, compares each against CONST_VALUE and emits
// one match/mismatch control token per input through a 2-entry result FIFO.
module handshake_constant_check #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] CONST_VALUE = '0,
    parameter int unsigned           CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  ctrl_valid,
    input  logic                  ctrl_ready,
    output logic                  ctrl_match,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic                  err
);

    logic [1:0] mem;
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] occ;
    logic       push;
    logic       pop;
    logic       match;

    // Readiness depends only on registered occupancy, so ctrl_ready never
    // reaches ins_ready combinationally.
    assign ins_ready  = (occ < 2'd2);
    assign ctrl_valid = (occ != 2'd0);
    assign ctrl_match = ctrl_valid ? mem[rd_ptr] : 1'b0;
    assign match      = (ins == CONST_VALUE);
    assign push       = ins_valid && ins_ready;
    assign pop        = ctrl_valid && ctrl_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem            <= '0;
            rd_ptr         <= 1'b0;
            wr_ptr         <= 1'b0;
            occ            <= 2'd0;
            mismatch_count <= '0;
            err            <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= match;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            if (push && !match) begin
                if (mismatch_count != '1) begin
                    mismatch_count <= mismatch_count + 1'b1;
                end
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_handshake_constant_check.sv
// Bench for handshake_constant_check: directed scenarios plus randomized traffic
// checked against a queue-based model of the result stream.
module tb_handshake_constant_check;

    localparam logic [31:0] C = 32'h5D85DE97;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ins = '0;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic        ctrl_valid;
    logic        ctrl_ready = 1'b0;
    logic        ctrl_match;
    logic [15:0] mismatch_count;
    logic        err;

    logic [31:0] s_ins = '0;
    logic        s_ins_valid = 1'b0;
    logic        s_ins_ready;
    logic        s_ctrl_valid;
    logic        s_ctrl_ready = 1'b1;
    logic        s_ctrl_match;
    logic [1:0]  s_mismatch_count;
    logic        s_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: ordered list of outstanding results plus counters.
    bit q[$];
    int m_cnt = 0;
    bit m_err = 0;

    handshake_constant_check #(
        .DATA_WIDTH (32),
        .CONST_VALUE(C),
        .CNT_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ins           (ins),
        .ins_valid     (ins_valid),
        .ins_ready     (ins_ready),
        .ctrl_valid    (ctrl_valid),
        .ctrl_ready    (ctrl_ready),
        .ctrl_match    (ctrl_match),
        .mismatch_count(mismatch_count),
        .err           (err)
    );

    handshake_constant_check #(
        .DATA_WIDTH (32),
        .CONST_VALUE(C),
        .CNT_WIDTH  (2)
    ) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .ins           (s_ins),
        .ins_valid     (s_ins_valid),
        .ins_ready     (s_ins_ready),
        .ctrl_valid    (s_ctrl_valid),
        .ctrl_ready    (s_ctrl_ready),
        .ctrl_match    (s_ctrl_match),
        .mismatch_count(s_mismatch_count),
        .err           (s_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply inputs for one cycle (called just after a falling edge) and advance the model.
    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        bit acc;
        bit pp;
        ins_valid  = v;
        ins        = d;
        ctrl_ready = r;
        acc = v && (q.size() < 2);
        pp  = (q.size() != 0) && r;
        @(posedge clk);
        if (pp) void'(q.pop_front());
        if (acc) begin
            q.push_back(d == C);
            if (d != C) begin
                if (m_cnt < 65535) m_cnt++;
                m_err = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        q.delete(); m_cnt = 0; m_err = 0;
        n_checks++; if (ins_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ins_ready: got %b expected 1", ins_ready); end
        n_checks++; if (ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_valid: got %b expected 0", ctrl_valid); end
        n_checks++; if (ctrl_match !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_match: got %b expected 0", ctrl_match); end
        n_checks++; if (mismatch_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", mismatch_count); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        drive(1'b0, '0, 1'b1);
        n_checks++; if (ctrl_valid !== 1'b0 || ins_ready !== 1'b1) begin n_fail++; $display("FAIL idle: got valid=%b ready=%b expected 0/1", ctrl_valid, ins_ready); end
    endtask

    task automatic test_stream();
        logic [31:0] toks [4] = '{32'h5D85DE97, 32'h00000000, 32'h5D85DE97, 32'hFFFFFFFF};
        bit          exp_m [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int          exp_c [4] = '{0, 1, 1, 2};
        bit          exp_e [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, toks[i], 1'b1);
            n_checks++; if (ctrl_valid !== 1'b1 || ctrl_match !== exp_m[i]) begin n_fail++; $display("FAIL stream_match[%0d]: got valid=%b match=%b expected 1/%b", i, ctrl_valid, ctrl_match, exp_m[i]); end
            n_checks++; if (mismatch_count !== 16'(exp_c[i]) || err !== exp_e[i]) begin n_fail++; $display("FAIL stream_cnt[%0d]: got cnt=%0d err=%b expected %0d/%b", i, mismatch_count, err, exp_c[i], exp_e[i]); end
        end
        drive(1'b0, '0, 1'b1);
        n_checks++; if (ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got valid=%b expected 0", ctrl_valid); end
    endtask

    task automatic test_stall();
        drive(1'b1, C, 1'b0);
        n_checks++; if (ctrl_match !== 1'b1 || ins_ready !== 1'b1) begin n_fail++; $display("FAIL stall_first: got match=%b ready=%b expected 1/1", ctrl_match, ins_ready); end
        drive(1'b1, 32'h12345678, 1'b0);
        n_checks++; if (ins_ready !== 1'b0 || ctrl_match !== 1'b1) begin n_fail++; $display("FAIL stall_full: got ready=%b match=%b expected 0/1", ins_ready, ctrl_match); end
        drive(1'b1, C, 1'b0);
        n_checks++; if (ins_ready !== 1'b0 || ctrl_match !== 1'b1 || ctrl_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got ready=%b match=%b valid=%b expected 0/1/1", ins_ready, ctrl_match, ctrl_valid); end
        drive(1'b1, C, 1'b1);
        n_checks++; if (ctrl_match !== 1'b0 || ins_ready !== 1'b1) begin n_fail++; $display("FAIL stall_pop1: got match=%b ready=%b expected 0/1", ctrl_match, ins_ready); end
        drive(1'b1, C, 1'b1);
        n_checks++; if (ctrl_valid !== 1'b1 || ctrl_match !== 1'b1) begin n_fail++; $display("FAIL stall_third: got valid=%b match=%b expected 1/1", ctrl_valid, ctrl_match); end
        drive(1'b0, '0, 1'b1);
        n_checks++; if (ctrl_valid !== 1'b0 || q.size() != 0) begin n_fail++; $display("FAIL stall_drain: got valid=%b expected 0", ctrl_valid); end
    endtask

    task automatic test_simul();
        drive(1'b1, 32'hDEADBEEF, 1'b0);
        n_checks++; if (ctrl_valid !== 1'b1 || ctrl_match !== 1'b0) begin n_fail++; $display("FAIL simul_setup: got valid=%b match=%b expected 1/0", ctrl_valid, ctrl_match); end
        drive(1'b1, C, 1'b1);
        n_checks++; if (ctrl_valid !== 1'b1 || ctrl_match !== 1'b1 || ins_ready !== 1'b1) begin n_fail++; $display("FAIL simul_pushpop: got valid=%b match=%b ready=%b expected 1/1/1", ctrl_valid, ctrl_match, ins_ready); end
        drive(1'b0, '0, 1'b1);
        n_checks++; if (ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drain: got valid=%b expected 0", ctrl_valid); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 1) == 0) ? C : $urandom;
            drive(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0));
            n_checks++; if (ins_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, ins_ready, q.size() < 2); end
            n_checks++; if (ctrl_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, ctrl_valid, q.size() != 0); end
            n_checks++; if (ctrl_match !== ((q.size() != 0) ? q[0] : 1'b0)) begin n_fail++; $display("FAIL rand_match[%0d]: got %b expected %b", i, ctrl_match, (q.size() != 0) ? q[0] : 1'b0); end
            n_checks++; if (mismatch_count !== 16'(m_cnt) || err !== m_err) begin n_fail++; $display("FAIL rand_cnt[%0d]: got cnt=%0d err=%b expected %0d/%b", i, mismatch_count, err, m_cnt, m_err); end
        end
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
    endtask

    task automatic test_saturation();
        int exp_c [5] = '{1, 2, 3, 3, 3};
        s_ctrl_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_ins_valid = 1'b1;
            s_ins       = 32'h0BAD0000 + 32'(i);
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (s_mismatch_count !== 2'(exp_c[i]) || s_err !== 1'b1) begin n_fail++; $display("FAIL sat_cnt[%0d]: got cnt=%0d err=%b expected %0d/1", i, s_mismatch_count, s_err, exp_c[i]); end
        end
        s_ins_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (s_mismatch_count !== 2'd3 || s_ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL sat_hold: got cnt=%0d valid=%b expected 3/0", s_mismatch_count, s_ctrl_valid); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h0, 1'b0);
        drive(1'b1, C, 1'b0);
        n_checks++; if (ctrl_valid !== 1'b1 || ins_ready !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL rmid_setup: got valid=%b ready=%b err=%b expected 1/0/1", ctrl_valid, ins_ready, err); end
        rst = 1'b1;
        ctrl_ready = 1'b0;
        ins_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete(); m_cnt = 0; m_err = 0;
        n_checks++; if (ctrl_valid !== 1'b0 || ins_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_flags: got valid=%b ready=%b expected 0/1", ctrl_valid, ins_ready); end
        n_checks++; if (mismatch_count !== 16'd0 || err !== 1'b0) begin n_fail++; $display("FAIL rmid_cnt: got cnt=%0d err=%b expected 0/0", mismatch_count, err); end
        n_checks++; if (s_mismatch_count !== 2'd0 || s_err !== 1'b0) begin n_fail++; $display("FAIL rmid_sat: got cnt=%0d err=%b expected 0/0", s_mismatch_count, s_err); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1);
            n_checks++; if (ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale[%0d]: got valid=%b expected 0", i, ctrl_valid); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_simul();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
